// File: rtl/dpram_port_arbiter.sv
// ---------------------------------------------------------------------------------------------
// dpram_port_arbiter
//
// Shares port 1 of a dual-port synchronous RAM between NUM_REQ fabric-side requesters.
// One access is granted per cycle (combinational one-hot gnt) and issued to the RAM one
// cycle later through registered strobes. Reads are tracked in a tag pipeline so the RAM
// read data is steered back to the requester that issued it, RAM_LATENCY+1 cycles after
// the grant.
//
// Optional feature (macro ARB_FIXED_PRIO0_EN):
//   defined   - requester 0 always wins when it requests; requesters 1..NUM_REQ-1
//               round-robin among themselves.
//   undefined - pure round-robin over all requesters.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   arb_en                 1 allows new grants; in-flight reads always complete
//   req / req_we           per-requester request and write(1)/read(0) select
//   req_addr / req_wdata   flattened per-requester address and write data
//   gnt                    one-hot grant, combinational
//   rd_valid / rd_data     one-hot read-return strobe and the returned word
//   ram_cs/we/oe           registered RAM strobes
//   ram_addr / ram_wdata   registered RAM address and write data
//   ram_rdata              RAM read data
// ---------------------------------------------------------------------------------------------
module dpram_port_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          arb_en,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          ram_cs,
    output logic                          ram_we,
    output logic                          ram_oe,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic                  win_valid;
    logic [IdxW-1:0]       win_idx;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    logic                  ram_cs_q, ram_cs_d;
    logic                  ram_we_q, ram_we_d;
    logic                  ram_oe_q, ram_oe_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

    // Stage k holds a read granted k+1 cycles ago; the last stage lines up with ram_rdata.
    logic [RAM_LATENCY:0] tag_v_q, tag_v_d;
    logic [IdxW-1:0]      tag_idx_q [RAM_LATENCY+1];
    logic [IdxW-1:0]      tag_idx_d [RAM_LATENCY+1];

    // Winner search: first pass covers indices above the pointer, second pass wraps around
    // to indices at or below it. Grants are suppressed while reset is asserted.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        if (arb_en && rst) begin
`ifdef ARB_FIXED_PRIO0_EN
            if (req[0]) begin
                win_valid = 1'b1;
            end
            for (int unsigned i = 1; i < NUM_REQ; i++) begin
                if (!win_valid && req[i] && (IdxW'(i) > ptr_q)) begin
                    win_valid = 1'b1;
                    win_idx   = IdxW'(i);
                end
            end
            for (int unsigned i = 1; i < NUM_REQ; i++) begin
                if (!win_valid && req[i] && (IdxW'(i) <= ptr_q)) begin
                    win_valid = 1'b1;
                    win_idx   = IdxW'(i);
                end
            end
`else
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!win_valid && req[i] && (IdxW'(i) > ptr_q)) begin
                    win_valid = 1'b1;
                    win_idx   = IdxW'(i);
                end
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!win_valid && req[i] && (IdxW'(i) <= ptr_q)) begin
                    win_valid = 1'b1;
                    win_idx   = IdxW'(i);
                end
            end
`endif
        end
    end

    // Winner's access fields.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IdxW'(i)) begin
                win_we    = req_we[i];
                win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_valid && (win_idx == IdxW'(i))) begin
                gnt[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
`ifdef ARB_FIXED_PRIO0_EN
        // Requester 0 sits outside the rotation.
        if (win_valid && (win_idx != '0)) begin
            ptr_d = win_idx;
        end
`else
        if (win_valid) begin
            ptr_d = win_idx;
        end
`endif
    end

    always_comb begin
        ram_cs_d    = win_valid;
        ram_we_d    = win_valid & win_we;
        ram_oe_d    = win_valid & ~win_we;
        ram_addr_d  = win_valid ? win_addr : ram_addr_q;
        ram_wdata_d = win_valid ? win_wdata : ram_wdata_q;
    end

    always_comb begin
        tag_v_d      = '0;
        tag_v_d[0]   = win_valid & ~win_we;
        tag_idx_d[0] = win_idx;
        for (int unsigned i = 1; i <= RAM_LATENCY; i++) begin
            tag_v_d[i]   = tag_v_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= IdxW'(NUM_REQ - 1);
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_oe_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            tag_v_q     <= '0;
            for (int unsigned i = 0; i <= RAM_LATENCY; i++) begin
                tag_idx_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            ram_oe_q    <= ram_oe_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            tag_v_q     <= tag_v_d;
            for (int unsigned i = 0; i <= RAM_LATENCY; i++) begin
                tag_idx_q[i] <= tag_idx_d[i];
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (tag_v_q[RAM_LATENCY] && (tag_idx_q[RAM_LATENCY] == IdxW'(i))) begin
                rd_valid[i] = 1'b1;
            end
        end
        rd_data = tag_v_q[RAM_LATENCY] ? ram_rdata : '0;
    end

    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_oe    = ram_oe_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Round-robin arbiter that shares one port of the dual-port synchronous RAM between NUM_REQ on-chip requesters, e.g. LED/PMOD refreshers and a status writer.
- Issues at most one RAM access per cycle, registered toward the RAM.
- Tracks in-flight reads in a tag pipeline so each read result returns to its originating requester with fixed latency.
- Sits between the fabric-side requesters and the port-1 side of the RAM; the GPMC bridge keeps port 0.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 4, RAM address width
DATA_WIDTH, 16, RAM data width
RAM_LATENCY, 1, cycles from RAM strobe cycle to valid ram_rdata (1..3)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
arb_en  in  1  1 = grants allowed; 0 = no new grants, in-flight reads still complete
req  in  NUM_REQ  per-requester access request, held until granted
req_we  in  NUM_REQ  per-requester 1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing
gnt  out  NUM_REQ  one-hot grant, combinational, for one cycle
rd_valid  out  NUM_REQ  one-hot read-return strobe
rd_data  out  DATA_WIDTH  read data, meaningful only while any rd_valid is 1
ram_cs  out  1  RAM chip select, active-high, registered
ram_we  out  1  RAM write strobe, active-high, registered
ram_oe  out  1  RAM read strobe, active-high, registered
ram_addr  out  ADDR_WIDTH  RAM address, registered
ram_wdata  out  DATA_WIDTH  RAM write data, registered
ram_rdata  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (rst=0, asynchronous):
  - ram_cs/we/oe=0; ram_addr=0; ram_wdata=0.
  - Tag pipeline cleared; rd_valid=0; rd_data=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- Arbitration, each cycle N:
  - If arb_en=1 and req!=0, the winner is the first set req bit searching upward from pointer+1 with wrap-around (index NUM_REQ-1 wraps to 0).
  - gnt[winner]=1 in cycle N, combinationally; gnt=0 when there is no winner.
  - Pointer updates to the winner at the end of cycle N; it is unchanged when there is no grant.
- Issue:
  - In cycle N+1, ram_cs=1, ram_addr and ram_wdata come from the winner's cycle-N inputs, ram_we=req_we[winner], ram_oe=~req_we[winner].
  - With no grant in cycle N, ram_cs/we/oe=0 in cycle N+1; addr and wdata hold their last values.
- Throughput:
  - One grant per cycle; back-to-back grants are allowed.
  - Every continuously requesting requester is granted at least once every NUM_REQ cycles.
- Requester rules:
  - Inputs must be stable while req=1 and gnt=0.
  - The cycle after gnt, the requester may hold req=1 to issue a new access; that access re-enters arbitration.
- Read return:
  - A tag pipeline of depth 1+RAM_LATENCY carries {valid, winner index} for reads only.
  - rd_valid[winner]=1 exactly in cycle N+1+RAM_LATENCY.
  - rd_data = ram_rdata registered-through into that cycle, i.e. equal to ram_rdata in cycle N+1+RAM_LATENCY.
  - Writes produce no rd_valid.
- arb_en=0: gnt=0, no new strobes, tag pipeline keeps draining.
- Reset mid-operation discards in-flight reads; no rd_valid is emitted for them.
- Unused requester bits with req=0 are ignored.

Optional Feature:
- Macro: ARB_FIXED_PRIO0_EN.
- Defined:
  - Requester 0 (GPMC-mirror or latency-critical client) wins whenever req[0]=1 and arb_en=1.
  - Requesters 1..NUM_REQ-1 round-robin among themselves; the pointer ignores grants to requester 0.
  - Starvation of the others is permitted.
- Undefined: pure round-robin over all NUM_REQ as above.

Test Plan:
- Reset check: hold rst=0 with req=4'b1111 -> gnt=0, ram_cs=0, rd_valid=0. Release rst -> first grant goes to requester 0.
- Single read: req=4'b0100, req_we=0, addr2=4'h5, RAM word 5=16'hA5A5, RAM_LATENCY=1:
  - gnt=4'b0100 in cycle N.
  - ram_cs=1, ram_oe=1, ram_addr=5 in N+1.
  - rd_valid=4'b0100 with rd_data=16'hA5A5 in N+2.
- Round-robin fairness: all four requesting continuously -> grant order 0,1,2,3,0,1,... with no requester waiting more than 4 cycles.
- Write then read: requester 1 writes 16'h1234 to addr 3; next cycle requester 2 reads addr 3 -> rd_valid[2] carries 16'h1234 and no rd_valid for the write.
- arb_en and reset mid-flight:
  - Drop arb_en after a read grant -> gnt=0 afterwards, but that read's rd_valid still fires.
  - Assert rst one cycle after a read grant -> no rd_valid ever appears for it.
- With ARB_FIXED_PRIO0_EN, req=4'b1011 held -> requester 0 granted every cycle. Drop req[0] -> grants alternate 1,3,1,3.
